// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } loader_state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CHK_W      = 8;

    function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                 input logic [7:0]       b);
        return acc + b;
    endfunction

    function automatic logic is_loading(input loader_state_t s);
        logic r;
        case (s)
            S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_CHECK: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes into little-endian 32-bit words; flags the byte that completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_r;
    logic [23:0] shift_r;

    // Lane counter and shift register for the three lower bytes of the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r  <= 2'd0;
            shift_r <= 24'd0;
        end else if (clr) begin
            lane_r  <= 2'd0;
            shift_r <= 24'd0;
        end else if (byte_en) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_data, shift_r[23:8]};
        end
    end

    assign word_valid = byte_en && (lane_r == 2'(WORD_BYTES - 1));
    assign word       = {byte_data, shift_r};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed image and writes it to instruction memory,
// holding the core in reset until the image verifies.
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH  = 1024,
    parameter int ADDR_W      = $clog2(IMEM_DEPTH),
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          LEN_W  = 8 * LEN_BYTES;
    localparam logic [31:0] TO_LIM = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0] DEPTH  = 32'(IMEM_DEPTH);

    loader_state_t     state_r, state_next_s;
    logic [LEN_W-1:0]  len_r, word_cnt_r, n_s;
    logic [CHK_W-1:0]  chk_r;
    logic [31:0]       idle_cnt_r;
    logic              rx_ready_r, imem_we_r, core_hold_r, busy_r, done_r, err_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              xfer_s, start_acc_s, pay_en_s, timeout_s, len_ok_s, last_word_s;
    logic              word_valid_s;
    logic [31:0]       word_s;

    assign xfer_s      = rx_valid && rx_ready_r;
    assign start_acc_s = start && !is_loading(state_r);
    assign pay_en_s    = xfer_s && (state_r == S_PAYLOAD);
    assign n_s         = {rx_data, len_r[7:0]};
    assign len_ok_s    = (n_s != LEN_W'(0)) && (32'(n_s) <= DEPTH);
    assign last_word_s = (word_cnt_r == len_r - LEN_W'(1));
    // Timeout fires on the idle edge that would bring the counter to TIMEOUT_CYC.
    assign timeout_s   = (TIMEOUT_CYC != 0) && !xfer_s && (idle_cnt_r == TO_LIM);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (start_acc_s),
        .byte_en    (pay_en_s),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next_s = S_LEN_LO;
                else       state_next_s = state_r;
            end
            S_LEN_LO: begin
                if (xfer_s)         state_next_s = S_LEN_HI;
                else if (timeout_s) state_next_s = S_ERR;
                else                state_next_s = state_r;
            end
            S_LEN_HI: begin
                if (xfer_s)         state_next_s = len_ok_s ? S_PAYLOAD : S_ERR;
                else if (timeout_s) state_next_s = S_ERR;
                else                state_next_s = state_r;
            end
            S_PAYLOAD: begin
                if (word_valid_s && last_word_s) state_next_s = S_CHECK;
                else if (timeout_s)              state_next_s = S_ERR;
                else                             state_next_s = state_r;
            end
            S_CHECK: begin
                if (xfer_s)         state_next_s = (rx_data == chk_r) ? S_DONE : S_ERR;
                else if (timeout_s) state_next_s = S_ERR;
                else                state_next_s = state_r;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and status outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            rx_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            core_hold_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            rx_ready_r  <= is_loading(state_next_s);
            busy_r      <= is_loading(state_next_s);
            done_r      <= (state_next_s == S_DONE);
            err_r       <= (state_next_s == S_ERR);
            core_hold_r <= (state_next_s != S_DONE);
        end
    end

    // Header capture, word counter, checksum and idle-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r      <= '0;
            word_cnt_r <= '0;
            chk_r      <= '0;
            idle_cnt_r <= 32'd0;
        end else if (start_acc_s) begin
            len_r      <= '0;
            word_cnt_r <= '0;
            chk_r      <= '0;
            idle_cnt_r <= 32'd0;
        end else begin
            if (xfer_s && state_r == S_LEN_LO) len_r[7:0]       <= rx_data;
            if (xfer_s && state_r == S_LEN_HI) len_r[LEN_W-1:8] <= rx_data;
            if (pay_en_s)     chk_r      <= chk_add(chk_r, rx_data);
            if (word_valid_s) word_cnt_r <= word_cnt_r + LEN_W'(1);
            if (is_loading(state_r)) idle_cnt_r <= xfer_s ? 32'd0 : idle_cnt_r + 32'd1;
            else                     idle_cnt_r <= 32'd0;
        end
    end

    // Memory write port: one-cycle strobe on the edge that completes each word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
        end else begin
            imem_we_r <= word_valid_s;
            if (word_valid_s) begin
                imem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                imem_wdata_r <= word_s;
            end
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign core_hold  = core_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

- Upstream of `processor`.
- Receives a program image as a byte stream (valid/ready) and assembles little-endian 32-bit words.
- Writes the words into instruction memory through a write port.
- Holds the core in reset until the image has loaded and its checksum verifies.
- Replaces the simulation-only `$readmemb` preload with a synthesizable boot path.

## Interface
Parameters:
- `IMEM_DEPTH`, 1024: instruction memory depth in words.
- `ADDR_W`, `$clog2(IMEM_DEPTH)`: word address width.
- `TIMEOUT_CYC`, 0: maximum idle cycles between accepted bytes while loading. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle pulse that begins a load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  `ADDR_W`  word address.
- `imem_wdata`  out  32  word to write.
- `core_hold`  out  1  active-high reset for `processor`.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load completed and checksum matched.
- `err`  out  1  load failed.

## Operation
- **Frame format:**
  - `LEN_LO`, `LEN_HI`: word count N, little-endian.
  - Then 4N payload bytes, little-endian within each word.
  - Then one check byte: the 8-bit sum (mod 256) of all payload bytes.
- **Handshake:** a byte transfers on a rising edge where `rx_valid && rx_ready`.
- **`rx_ready`:** high only in `S_LEN_LO`, `S_LEN_HI`, `S_PAYLOAD` and `S_CHECK`. It has no combinational path from `rx_valid`.
- **FSM states:** `S_IDLE`, `S_LEN_LO`, `S_LEN_HI`, `S_PAYLOAD`, `S_CHECK`, `S_DONE`, `S_ERR`.
- **Transitions:**
  - `S_IDLE`/`S_DONE`/`S_ERR` + `start` → `S_LEN_LO`.
    - Clears `done`, `err`, the byte counter, the word counter and the checksum.
    - Sets `core_hold` = 1.
  - `start` is ignored in every other state.
  - `S_LEN_LO` → `S_LEN_HI` on a transfer.
  - `S_LEN_HI` → `S_PAYLOAD` on a transfer if 1 ≤ N ≤ `IMEM_DEPTH`, else → `S_ERR`.
  - `S_PAYLOAD` → `S_CHECK` after the 4N-th byte.
  - `S_CHECK` → `S_DONE` if the received check byte equals the computed sum, else → `S_ERR`.
  - Any loading state → `S_ERR` if `TIMEOUT_CYC` ≠ 0 and the idle-cycle counter reaches `TIMEOUT_CYC`. The counter resets on every transfer.
- **Checksum and write sequencing:**
  - The 8-bit checksum accumulates every payload byte; overflow wraps.
  - The 2-bit byte counter wraps 3 → 0 on each completed word.
  - The word counter increments after each write.
- **`core_hold`:** 1 in all states except `S_DONE`.
  - In `S_ERR`, stale partial image data may remain in memory; the core stays held.
- **Status outputs:**
  - `busy` = state ∈ {`S_LEN_LO`..`S_CHECK`}.
  - `done` = state is `S_DONE`.
  - `err` = state is `S_ERR`.
  - All three are registered.

## Timing
- **Reset values:**
  - state `S_IDLE`.
  - `rx_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0.
  - `core_hold` 1.
  - `busy` 0, `done` 0, `err` 0.
- **Write latency:** the edge accepting the 4th byte of word k registers `imem_we` = 1, `imem_addr` = k and the full word. The strobe is high for exactly one cycle.
  - Accepting the next word's first byte on that same cycle is legal.
  - Full rate is 1 byte/cycle.
- **Status latency:**
  - `done` and `core_hold` = 0 are visible the cycle after the check byte is accepted.
  - `err` is visible the cycle after the failing byte or the timeout.
- **Reset mid-load:** returns to `S_IDLE` with reset values and issues no further write. Memory contents already written are undefined.

## Structure
- **`loader_pkg`:**
  - `loader_state_t` enum.
  - `LEN_BYTES` = 2.
  - `WORD_BYTES` = 4.
  - `CHK_W` = 8.
- **Sub-module `word_assembler`:**
  - Byte-lane shift register plus 2-bit lane counter.
  - Outputs `word_valid` and `word`.
  - Instantiated once; the FSM owns addressing and checksum.

## Test plan
- Load N = 2 with payload `00500093` `00A00113` (bytes `93 00 50 00 13 01 A0 00`) and check byte `0x97`.
  - Expect two `imem_we` pulses: addr 0 = `0x00500093`, addr 1 = `0x00A00113`.
  - Then `done` = 1 and `core_hold` = 0.
- Same frame with check byte `0x98`.
  - Expect both writes to occur, `err` = 1 and `core_hold` stays 1.
- Header N = 0, and separately N = `IMEM_DEPTH` + 1.
  - Expect `S_ERR` right after `LEN_HI` with no `imem_we`.
- Random `rx_valid` gaps, with `TIMEOUT_CYC` = 16 and 15-cycle gaps.
  - Expect an identical memory image and `done`.
  - A 16-cycle gap mid-payload gives `err` = 1.
- Assert `rst` low after byte 5 of a load, then replay the full frame.
  - Expect outputs at reset values while `rst` is low and no write after reset.
  - The replayed load succeeds.
- `start` pulsed while `busy`: ignored.
- `start` in `S_DONE`: `core_hold` returns to 1 the next cycle and a new load completes.
